rx_udp_channel_demux: RTL and testbench
=======================================

// Module: rx_udp_channel_demux
// PURPOSE
//  Parametrised successor to the fixed sound/screen RX MAC parser. Sits between the Ethernet MAC RX
//  byte stream (LocalLink, active-low framing) and the application sinks. Filters on dest MAC, decodes
//  IPv4/UDP, strips the 42 header bytes and steers payload to one of NUM_CH channels by UDP dest port.
//  Also detects ARP requests for LOCAL_IP and captures sender MAC/IP; counts dropped frames.
// PARAMETERS
//  LOCAL_MAC   48'h000A35000001          station MAC; frames to it or to FF..FF are accepted
//  LOCAL_IP    32'hC0A80102              station IP; ARP target compare and IPv4 dest compare
//  NUM_CH      4                         number of UDP channels, 1..8
//  PORT_TABLE  {16'd5003,16'd5002,16'd5001,16'd5000}  NUM_CH*16 bits, channel i = bits [16i+15:16i]
//  CNT_W       16                        drop counter width
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset        in   1          asynchronous, active-high
//  rx_data      in   8          MAC RX byte
//  rx_sof       in   1          active-low, first byte of frame
//  rx_eof       in   1          active-low, last byte of frame
//  rx_src_rdy   in   1          active-low, byte valid; byte accepted when 0
//  mac_error    in   1          active-high, FCS/PHY error, sampled with any accepted byte
//  sof          out  1          active-high, first payload byte on data_rx
//  eof          out  1          active-high, last payload byte on data_rx
//  rx_valid     out  1          data_rx holds a payload byte
//  data_rx      out  8          payload byte
//  length_rx    out  16         UDP payload length (UDP length - 8), valid sof..eof
//  ch_hit       out  NUM_CH     one-hot matched channel, held sof..eof
//  busy         out  1          frame in progress (any state but IDLE)
//  rx_error     out  1          1-cycle pulse, current frame aborted
//  arp          out  1          1-cycle pulse, ARP request for LOCAL_IP captured
//  arp_mac      out  48         sender MAC of last ARP request (held)
//  arp_ip       out  32         sender IP of last ARP request (held)
//  drop_count   out  CNT_W      frames discarded (filter miss or error), saturates at all-ones
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, byte counter 0. Reset mid-frame abandons frame silently.
//  - Byte index b counts accepted bytes from rx_sof (b=0). Cycles with rx_src_rdy=1 are stalls: no state change.
//  - States: IDLE -> ETH_HDR on accepted rx_sof. ETH_HDR (b 0..13): dest MAC b0..5 must equal LOCAL_MAC or
//    broadcast; EtherType b12..13: 0x0800 -> IP_HDR, 0x0806 -> ARP_BODY, else DISCARD.
//  - IP_HDR (b14..33): b14 must be 0x45, b23 (protocol) 0x11, b30..33 == LOCAL_IP; else DISCARD.
//  - UDP_HDR (b34..41): port b36..37 compared with all PORT_TABLE entries; lowest index match wins;
//    no match -> DISCARD. UDP length b38..39 < 8 -> DISCARD. Else -> PAYLOAD at b42.
//  - PAYLOAD: registered, 1-cycle latency: byte accepted at edge n appears on data_rx with rx_valid at n+1.
//    sof with first byte; eof on byte where payload count == length_rx. Bytes beyond (Ethernet padding)
//    dropped -> DISCARD until rx_eof. length_rx==0: no payload beats, frame ends silently.
//  - ARP_BODY: opcode b20..21 must be 0x0001, target IP b38..41 == LOCAL_IP; sender MAC b22..27 and
//    sender IP b28..31 go to shadow regs, copied to arp_mac/arp_ip with arp pulse on b41 only if all match.
//  - DISCARD: wait for accepted rx_eof -> IDLE; drop_count +1 once per frame.
//  - Errors: mac_error on accepted byte, or rx_eof before header/payload complete -> rx_error pulse next
//    cycle; if PAYLOAD was active, eof also asserted on that cycle (rx_valid=0); drop_count +1; -> IDLE
//    (or DISCARD if rx_eof not yet seen).
//  - rx_sof while busy: current frame aborted as error, new frame starts at b=0 same cycle.
//  - rx_eof and rx_sof on same byte: runt, counted as drop, no rx_error.
// TESTING
//  1 UDP to port 5001, 10-byte payload 01..0A -> sof on 01, eof on 0A, ch_hit=4'b0010, length_rx=10.
//  2 Same frame with 20 bytes padding after UDP len 18 -> exactly 10 payload beats, no rx_error.
//  3 ARP request target LOCAL_IP, sender 11:22:33:44:55:66 / 10.0.0.7 -> arp pulse, arp_mac/ip held.
//  4 Port 6000, then wrong dest MAC -> no rx_valid, drop_count 0->2.
//  5 mac_error on 5th payload byte -> rx_error+eof pulse, drop_count+1, next frame decodes normally.
//  6 reset asserted mid-PAYLOAD -> all outputs 0 immediately, next frame decodes normally.

Source files
------------

// File: rtl/rx_udp_channel_demux.sv
// Ethernet RX parser: filters on dest MAC, decodes IPv4/UDP, strips 42 header bytes and steers
// payload to one of NUM_CH channels by UDP dest port; also captures ARP requests for LOCAL_IP.
module rx_udp_channel_demux #(
   parameter logic [47:0]          LOCAL_MAC  = 48'h000A35000001,
   parameter logic [31:0]          LOCAL_IP   = 32'hC0A80102,
   parameter int unsigned          NUM_CH     = 4,
   parameter logic [NUM_CH*16-1:0] PORT_TABLE = {16'd5003, 16'd5002, 16'd5001, 16'd5000},
   parameter int unsigned          CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_sof,
   input  logic              rx_eof,
   input  logic              rx_src_rdy,
   input  logic              mac_error,
   output logic              sof,
   output logic              eof,
   output logic              rx_valid,
   output logic [7:0]        data_rx,
   output logic [15:0]       length_rx,
   output logic [NUM_CH-1:0] ch_hit,
   output logic              busy,
   output logic              rx_error,
   output logic              arp,
   output logic [47:0]       arp_mac,
   output logic [31:0]       arp_ip,
   output logic [CNT_W-1:0]  drop_count
);

   typedef enum logic [2:0] {
      StIdle, StEthHdr, StIpHdr, StUdpHdr, StPayload, StArpBody, StDiscard
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         b_q, b_d;
   logic [7:0]          prev_q, prev_d;
   logic                mac_loc_q, mac_loc_d;
   logic                mac_bc_q, mac_bc_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         pay_cnt_q, pay_cnt_d;
   logic [NUM_CH-1:0]   ch_sel_q, ch_sel_d;
   logic                arp_ok_q, arp_ok_d;
   logic [47:0]         mac_sh_q, mac_sh_d;
   logic [31:0]         ip_sh_q, ip_sh_d;
   logic                sof_q, sof_d;
   logic                eof_q, eof_d;
   logic                valid_q, valid_d;
   logic [7:0]          data_q, data_d;
   logic [15:0]         length_q, length_d;
   logic [NUM_CH-1:0]   ch_hit_q, ch_hit_d;
   logic                rx_error_q, rx_error_d;
   logic                arp_q, arp_d;
   logic [47:0]         arp_mac_q, arp_mac_d;
   logic [31:0]         arp_ip_q, arp_ip_d;
   logic [CNT_W-1:0]    drop_q, drop_d;

   logic                acc, sof_in, eof_in;
   logic [15:0]         word;
   logic [1:0]          ip_k;
   logic                loc_now, bc_now;
   logic [NUM_CH-1:0]   ch_match;
   logic                miss, done, err, start_pay, last;
   logic [1:0]          drop_inc;
   logic [CNT_W:0]      drop_sum;

   function automatic logic [7:0] mac_byte(input logic [2:0] k);
      case (k)
         3'd0:    mac_byte = LOCAL_MAC[47:40];
         3'd1:    mac_byte = LOCAL_MAC[39:32];
         3'd2:    mac_byte = LOCAL_MAC[31:24];
         3'd3:    mac_byte = LOCAL_MAC[23:16];
         3'd4:    mac_byte = LOCAL_MAC[15:8];
         default: mac_byte = LOCAL_MAC[7:0];
      endcase
   endfunction

   function automatic logic [7:0] ip_byte(input logic [1:0] k);
      case (k)
         2'd0:    ip_byte = LOCAL_IP[31:24];
         2'd1:    ip_byte = LOCAL_IP[23:16];
         2'd2:    ip_byte = LOCAL_IP[15:8];
         default: ip_byte = LOCAL_IP[7:0];
      endcase
   endfunction

   always_comb begin
      acc     = ~rx_src_rdy;
      sof_in  = acc & ~rx_sof;
      eof_in  = acc & ~rx_eof;
      word    = {prev_q, rx_data};
      // IP compare windows start at b30 and b38; both map to k = 0 with this offset
      ip_k    = b_q[1:0] + 2'd2;
      loc_now = mac_loc_q & (rx_data == mac_byte(b_q[2:0]));
      bc_now  = mac_bc_q & (rx_data == 8'hFF);
      ch_match = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (PORT_TABLE[16*i +: 16] == word) begin
            ch_match    = '0;
            ch_match[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      b_d        = b_q;
      prev_d     = prev_q;
      mac_loc_d  = mac_loc_q;
      mac_bc_d   = mac_bc_q;
      len_d      = len_q;
      pay_cnt_d  = pay_cnt_q;
      ch_sel_d   = ch_sel_q;
      arp_ok_d   = arp_ok_q;
      mac_sh_d   = mac_sh_q;
      ip_sh_d    = ip_sh_q;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      valid_d    = 1'b0;
      data_d     = data_q;
      length_d   = length_q;
      ch_hit_d   = ch_hit_q;
      rx_error_d = 1'b0;
      arp_d      = 1'b0;
      arp_mac_d  = arp_mac_q;
      arp_ip_d   = arp_ip_q;
      miss       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      start_pay  = 1'b0;
      last       = 1'b0;
      drop_inc   = 2'd0;

      // Channel and length stay visible through the eof cycle, then clear
      if (eof_q) begin
         ch_hit_d = '0;
         length_d = '0;
      end

      if (acc) begin
         prev_d = rx_data;
         if (sof_in) begin
            if (state_q != StIdle) begin
               err      = 1'b1;
               drop_inc = drop_inc + 2'd1;
            end
            if (eof_in) begin
               state_d  = StIdle;
               b_d      = 16'd0;
               drop_inc = drop_inc + 2'd1;
            end else if (mac_error) begin
               err      = 1'b1;
               drop_inc = drop_inc + 2'd1;
               state_d  = StDiscard;
            end else begin
               state_d   = StEthHdr;
               b_d       = 16'd1;
               mac_loc_d = (rx_data == LOCAL_MAC[47:40]);
               mac_bc_d  = (rx_data == 8'hFF);
            end
         end else if (state_q == StDiscard) begin
            if (eof_in) state_d = StIdle;
         end else if (state_q != StIdle) begin
            if (mac_error) begin
               err      = 1'b1;
               drop_inc = 2'd1;
               state_d  = eof_in ? StIdle : StDiscard;
            end else if (state_q == StPayload) begin
               last = (pay_cnt_q + 16'd1 == length_q);
               if (eof_in && !last) begin
                  err      = 1'b1;
                  drop_inc = 2'd1;
                  state_d  = StIdle;
               end else begin
                  valid_d   = 1'b1;
                  data_d    = rx_data;
                  sof_d     = (pay_cnt_q == 16'd0);
                  eof_d     = last;
                  pay_cnt_d = pay_cnt_q + 16'd1;
                  if (last) state_d = eof_in ? StIdle : StDiscard;
               end
            end else begin
               b_d = b_q + 16'd1;
               unique case (state_q)
                  StEthHdr: begin
                     if (b_q <= 16'd5) begin
                        mac_loc_d = loc_now;
                        mac_bc_d  = bc_now;
                        if (b_q == 16'd5 && !(loc_now || bc_now)) miss = 1'b1;
                     end
                     if (b_q == 16'd13) begin
                        if (word == 16'h0800) begin
                           state_d = StIpHdr;
                        end else if (word == 16'h0806) begin
                           state_d  = StArpBody;
                           arp_ok_d = 1'b1;
                        end else begin
                           miss = 1'b1;
                        end
                     end
                  end
                  StIpHdr: begin
                     if (b_q == 16'd14 && rx_data != 8'h45) miss = 1'b1;
                     if (b_q == 16'd23 && rx_data != 8'h11) miss = 1'b1;
                     if (b_q >= 16'd30 && rx_data != ip_byte(ip_k)) miss = 1'b1;
                     if (b_q == 16'd33) state_d = StUdpHdr;
                  end
                  StUdpHdr: begin
                     if (b_q == 16'd37) begin
                        ch_sel_d = ch_match;
                        if (ch_match == '0) miss = 1'b1;
                     end
                     if (b_q == 16'd39) begin
                        len_d = word;
                        if (word < 16'd8) miss = 1'b1;
                     end
                     if (b_q == 16'd41) begin
                        if (len_q == 16'd8) done = 1'b1;
                        else start_pay = 1'b1;
                     end
                  end
                  StArpBody: begin
                     if (b_q == 16'd21 && word != 16'h0001) arp_ok_d = 1'b0;
                     if (b_q >= 16'd22 && b_q <= 16'd27) mac_sh_d = {mac_sh_q[39:0], rx_data};
                     if (b_q >= 16'd28 && b_q <= 16'd31) ip_sh_d = {ip_sh_q[23:0], rx_data};
                     if (b_q >= 16'd38 && rx_data != ip_byte(ip_k)) arp_ok_d = 1'b0;
                     if (b_q == 16'd41) done = 1'b1;
                  end
                  default: ;
               endcase

               if (eof_in && !done) begin
                  err      = 1'b1;
                  drop_inc = 2'd1;
                  state_d  = StIdle;
               end else if (miss) begin
                  drop_inc = 2'd1;
                  state_d  = eof_in ? StIdle : StDiscard;
               end else if (done) begin
                  // Trailing bytes after a complete zero-length UDP or ARP body are padding
                  state_d = eof_in ? StIdle : StDiscard;
                  if (state_q == StArpBody) begin
                     if (arp_ok_d) begin
                        arp_d     = 1'b1;
                        arp_mac_d = mac_sh_q;
                        arp_ip_d  = ip_sh_q;
                     end else begin
                        drop_inc = 2'd1;
                     end
                  end
               end else if (start_pay) begin
                  state_d   = StPayload;
                  pay_cnt_d = 16'd0;
                  length_d  = len_q - 16'd8;
                  ch_hit_d  = ch_sel_q;
               end
            end
         end
      end

      if (err) begin
         rx_error_d = 1'b1;
         if (state_q == StPayload) eof_d = 1'b1;
      end

      drop_sum = {1'b0, drop_q} + {{(CNT_W-1){1'b0}}, drop_inc};
      drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         b_q        <= '0;
         prev_q     <= '0;
         mac_loc_q  <= 1'b0;
         mac_bc_q   <= 1'b0;
         len_q      <= '0;
         pay_cnt_q  <= '0;
         ch_sel_q   <= '0;
         arp_ok_q   <= 1'b0;
         mac_sh_q   <= '0;
         ip_sh_q    <= '0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         length_q   <= '0;
         ch_hit_q   <= '0;
         rx_error_q <= 1'b0;
         arp_q      <= 1'b0;
         arp_mac_q  <= '0;
         arp_ip_q   <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         b_q        <= b_d;
         prev_q     <= prev_d;
         mac_loc_q  <= mac_loc_d;
         mac_bc_q   <= mac_bc_d;
         len_q      <= len_d;
         pay_cnt_q  <= pay_cnt_d;
         ch_sel_q   <= ch_sel_d;
         arp_ok_q   <= arp_ok_d;
         mac_sh_q   <= mac_sh_d;
         ip_sh_q    <= ip_sh_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         length_q   <= length_d;
         ch_hit_q   <= ch_hit_d;
         rx_error_q <= rx_error_d;
         arp_q      <= arp_d;
         arp_mac_q  <= arp_mac_d;
         arp_ip_q   <= arp_ip_d;
         drop_q     <= drop_d;
      end
   end

   assign sof        = sof_q;
   assign eof        = eof_q;
   assign rx_valid   = valid_q;
   assign data_rx    = data_q;
   assign length_rx  = length_q;
   assign ch_hit     = ch_hit_q;
   assign busy       = (state_q != StIdle);
   assign rx_error   = rx_error_q;
   assign arp        = arp_q;
   assign arp_mac    = arp_mac_q;
   assign arp_ip     = arp_ip_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_rx_udp_channel_demux.sv
// Directed bench for rx_udp_channel_demux: builds frames byte by byte and checks payload,
// channel steering, ARP capture, drop counting, error pulses and reset behaviour.
module tb_rx_udp_channel_demux;

   localparam logic [47:0] LOCAL_MAC = 48'h000A35000001;
   localparam logic [31:0] LOCAL_IP  = 32'hC0A80102;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_sof, rx_eof, rx_src_rdy, mac_error;
   logic        sof, eof, rx_valid;
   logic [7:0]  data_rx;
   logic [15:0] length_rx;
   logic [3:0]  ch_hit;
   logic        busy, rx_error, arp;
   logic [47:0] arp_mac;
   logic [31:0] arp_ip;
   logic [15:0] drop_count;

   rx_udp_channel_demux #(
      .LOCAL_MAC  (LOCAL_MAC),
      .LOCAL_IP   (LOCAL_IP),
      .NUM_CH     (4),
      .PORT_TABLE ({16'd5003, 16'd5002, 16'd5001, 16'd5000}),
      .CNT_W      (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_sof     (rx_sof),
      .rx_eof     (rx_eof),
      .rx_src_rdy (rx_src_rdy),
      .mac_error  (mac_error),
      .sof        (sof),
      .eof        (eof),
      .rx_valid   (rx_valid),
      .data_rx    (data_rx),
      .length_rx  (length_rx),
      .ch_hit     (ch_hit),
      .busy       (busy),
      .rx_error   (rx_error),
      .arp        (arp),
      .arp_mac    (arp_mac),
      .arp_ip     (arp_ip),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Output monitor, sampled on the falling edge
   logic [7:0]  beats[$];
   int          sof_cnt = 0, eof_cnt = 0, err_cnt = 0, err_eof_cnt = 0, arp_cnt = 0;
   logic [15:0] len_at_sof = '0;
   logic [3:0]  ch_at_sof = '0;

   always @(negedge clk) begin
      if (rx_valid) begin
         beats.push_back(data_rx);
         if (sof) begin
            sof_cnt++;
            len_at_sof = length_rx;
            ch_at_sof  = ch_hit;
         end
         if (eof) eof_cnt++;
      end
      if (rx_error) err_cnt++;
      if (rx_error && eof && !rx_valid) err_eof_cnt++;
      if (arp) arp_cnt++;
   end

   int b0, s0, e0, r0, re0, a0;

   task automatic snap();
      b0 = beats.size(); s0 = sof_cnt; e0 = eof_cnt;
      r0 = err_cnt; re0 = err_eof_cnt; a0 = arp_cnt;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] frm[$];

   task automatic put16(input logic [15:0] v);
      frm.push_back(v[15:8]);
      frm.push_back(v[7:0]);
   endtask

   task automatic put_mac(input logic [47:0] m);
      for (int i = 5; i >= 0; i--) frm.push_back(m[8*i +: 8]);
   endtask

   task automatic put_ip(input logic [31:0] a);
      for (int i = 3; i >= 0; i--) frm.push_back(a[8*i +: 8]);
   endtask

   task automatic build_udp(input logic [47:0] dmac, input logic [15:0] port,
                            input logic [15:0] ulen, input int npay, input int npad);
      frm.delete();
      put_mac(dmac); put_mac(48'h020000000099); put16(16'h0800);
      put16(16'h4500); put16(16'd20 + ulen); put16(16'h0000); put16(16'h0000);
      put16(16'h4011); put16(16'h0000); put_ip(32'hC0A80163); put_ip(LOCAL_IP);
      put16(16'd40000); put16(port); put16(ulen); put16(16'h0000);
      for (int i = 0; i < npay; i++) frm.push_back(8'(i + 1));
      for (int i = 0; i < npad; i++) frm.push_back(8'hEE);
   endtask

   task automatic build_arp();
      frm.delete();
      put_mac(48'hFFFFFFFFFFFF); put_mac(48'h112233445566); put16(16'h0806);
      put16(16'h0001); put16(16'h0800); put16(16'h0604); put16(16'h0001);
      put_mac(48'h112233445566); put_ip(32'h0A000007);
      put_mac(48'h000000000000); put_ip(LOCAL_IP);
      for (int i = 0; i < 18; i++) frm.push_back(8'h00);
   endtask

   // Stall cycles carry garbage framing that must be ignored
   task automatic send(input int n, input bit mark_eof, input int err_idx, input int stall_every);
      for (int i = 0; i < n; i++) begin
         if (stall_every > 0 && (i % stall_every) == stall_every - 1) begin
            rx_src_rdy = 1'b1; rx_data = 8'h5A; rx_sof = 1'b0; rx_eof = 1'b0; mac_error = 1'b1;
            @(posedge clk); #1;
         end
         rx_src_rdy = 1'b0;
         rx_data    = frm[i];
         rx_sof     = (i != 0);
         rx_eof     = !(mark_eof && i == n - 1);
         mac_error  = (i == err_idx);
         @(posedge clk); #1;
      end
      rx_src_rdy = 1'b1; rx_sof = 1'b1; rx_eof = 1'b1; mac_error = 1'b0; rx_data = 8'h00;
   endtask

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rx_data = 8'h00; rx_sof = 1'b1; rx_eof = 1'b1; rx_src_rdy = 1'b1; mac_error = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_valid", 64'(rx_valid), 64'd0);
      check("reset_drop", 64'(drop_count), 64'd0);
      check("reset_arp_mac", 64'(arp_mac), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // UDP to 5001, 10-byte payload, checked for 1-cycle latency on the last beat
      snap();
      build_udp(LOCAL_MAC, 16'd5001, 16'd18, 10, 0);
      send(frm.size(), 1'b1, -1, 0);
      @(negedge clk);
      check("t1_last_eof", 64'(eof), 64'd1);
      check("t1_last_valid", 64'(rx_valid), 64'd1);
      check("t1_last_data", 64'(data_rx), 64'h0A);
      idle(3);
      check("t1_beats", 64'(beats.size() - b0), 64'd10);
      check("t1_sof", 64'(sof_cnt - s0), 64'd1);
      check("t1_eof", 64'(eof_cnt - e0), 64'd1);
      check("t1_len", 64'(len_at_sof), 64'd10);
      check("t1_ch", 64'(ch_at_sof), 64'b0010);
      check("t1_err", 64'(err_cnt - r0), 64'd0);
      for (int i = 0; i < 10; i++) check("t1_payload", 64'(beats[b0 + i]), 64'(i + 1));
      check("t1_busy", 64'(busy), 64'd0);

      // Same frame with 20 padding bytes and stalls
      snap();
      build_udp(LOCAL_MAC, 16'd5001, 16'd18, 10, 20);
      send(frm.size(), 1'b1, -1, 4);
      idle(3);
      check("t2_beats", 64'(beats.size() - b0), 64'd10);
      check("t2_eof", 64'(eof_cnt - e0), 64'd1);
      check("t2_last", 64'(beats[b0 + 9]), 64'h0A);
      check("t2_err", 64'(err_cnt - r0), 64'd0);
      check("t2_drop", 64'(drop_count), 64'd0);

      // ARP request for LOCAL_IP
      snap();
      build_arp();
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("t3_arp_pulse", 64'(arp_cnt - a0), 64'd1);
      check("t3_arp_mac", 64'(arp_mac), 64'h112233445566);
      check("t3_arp_ip", 64'(arp_ip), 64'h0A000007);
      check("t3_beats", 64'(beats.size() - b0), 64'd0);
      check("t3_drop", 64'(drop_count), 64'd0);

      // Unknown port, then wrong dest MAC
      snap();
      build_udp(LOCAL_MAC, 16'd6000, 16'd18, 10, 0);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("t4_drop_port", 64'(drop_count), 64'd1);
      build_udp(48'h000A35000002, 16'd5001, 16'd18, 10, 0);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("t4_drop_mac", 64'(drop_count), 64'd2);
      check("t4_beats", 64'(beats.size() - b0), 64'd0);
      check("t4_err", 64'(err_cnt - r0), 64'd0);

      // mac_error on 5th payload byte, then a clean frame to 5003
      snap();
      build_udp(LOCAL_MAC, 16'd5002, 16'd18, 10, 0);
      send(frm.size(), 1'b1, 46, 0);
      idle(3);
      check("t5_beats", 64'(beats.size() - b0), 64'd4);
      check("t5_err", 64'(err_cnt - r0), 64'd1);
      check("t5_err_eof", 64'(err_eof_cnt - re0), 64'd1);
      check("t5_drop", 64'(drop_count), 64'd3);
      snap();
      build_udp(LOCAL_MAC, 16'd5003, 16'd18, 10, 0);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("t5_next_beats", 64'(beats.size() - b0), 64'd10);
      check("t5_next_ch", 64'(ch_at_sof), 64'b1000);
      check("t5_next_drop", 64'(drop_count), 64'd3);

      // Boundaries: zero-length UDP, short UDP length, runt, early eof in IP header
      snap();
      build_udp(LOCAL_MAC, 16'd5000, 16'd8, 0, 18);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("b_len0_beats", 64'(beats.size() - b0), 64'd0);
      check("b_len0_err", 64'(err_cnt - r0), 64'd0);
      check("b_len0_drop", 64'(drop_count), 64'd3);
      build_udp(LOCAL_MAC, 16'd5000, 16'd4, 0, 18);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("b_short_drop", 64'(drop_count), 64'd4);
      send(1, 1'b1, -1, 0);
      idle(3);
      check("b_runt_drop", 64'(drop_count), 64'd5);
      check("b_runt_err", 64'(err_cnt - r0), 64'd0);
      build_udp(LOCAL_MAC, 16'd5000, 16'd18, 10, 0);
      send(20, 1'b1, -1, 0);
      idle(3);
      check("b_early_err", 64'(err_cnt - r0), 64'd1);
      check("b_early_eof", 64'(err_eof_cnt - re0), 64'd0);
      check("b_early_drop", 64'(drop_count), 64'd6);

      // Reset in the middle of payload
      build_udp(LOCAL_MAC, 16'd5000, 16'd18, 10, 0);
      send(47, 1'b0, -1, 0);
      #2;
      reset = 1'b1;
      #1;
      check("r_busy", 64'(busy), 64'd0);
      check("r_valid", 64'(rx_valid), 64'd0);
      check("r_data", 64'(data_rx), 64'd0);
      check("r_ch", 64'(ch_hit), 64'd0);
      check("r_len", 64'(length_rx), 64'd0);
      check("r_drop", 64'(drop_count), 64'd0);
      check("r_arp_ip", 64'(arp_ip), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);
      snap();
      build_udp(LOCAL_MAC, 16'd5000, 16'd18, 10, 0);
      send(frm.size(), 1'b1, -1, 0);
      idle(3);
      check("r_next_beats", 64'(beats.size() - b0), 64'd10);
      check("r_next_ch", 64'(ch_at_sof), 64'b0001);
      check("r_next_sof", 64'(sof_cnt - s0), 64'd1);
      check("r_next_drop", 64'(drop_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
